// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl: arbitrates two ratio requesters and sequences each ratio
// change into the programmable clock divider without glitches. The divider is
// gated, the ratio is loaded, the divider is re-enabled, the sequencer waits for
// the divider output to settle, and then the granted requester gets an ack.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; arbitration happens here
// GATE   | clk_En held low for GATE_CYC clocks before the ratio changes
// LOAD   | new ratio written to Div_rat (clk_En still low)
// ENABLE | clk_En restored (ratio >= 2); wait S clocks for settling
// ACK    | one-clock ack pulse to the granted requester
module clk_div_cfg_ctrl #(
  parameter int unsigned GATE_CYC = 2,
  parameter logic [7:0]  RST_RAT  = 8'd8,
  parameter logic        RST_EN   = 1'b0
) (
  input  logic       ref_clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [7:0] rat_a,
  input  logic       req_b,
  input  logic [7:0] rat_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [7:0] Div_rat,
  output logic       clk_En,
  output logic       busy,
  output logic       gnt_b
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATE,
    ST_LOAD,
    ST_ENABLE,
    ST_ACK
  } state_t;

  // Terminal count of the gating window (cnt runs 0..GATE_CYC-1).
  localparam logic [7:0] GATE_LAST = 8'(GATE_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rat_q, rat_d;
  logic [7:0] div_q, div_d;
  logic       en_q, en_d;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic       busy_q, busy_d;
  logic       gnt_b_q, gnt_b_d;

  logic       grant;
  logic       grant_b;
  logic [7:0] rat_sel;
  logic       rat_sel_en;
  logic       rat_q_en;
  logic [7:0] enable_last;

  assign grant      = req_a | req_b;
  assign rat_sel    = grant_b ? rat_b : rat_a;
  // Ratios 0 and 1 put the divider in bypass, so it stays disabled.
  assign rat_sel_en = (rat_sel >= 8'd2);
  assign rat_q_en   = (rat_q >= 8'd2);
  // Settling lasts R clocks for a real ratio and a single clock in bypass.
  // Largest value is 254, so the 8-bit counter never wraps before it.
  assign enable_last = rat_q_en ? (rat_q - 8'd1) : 8'd0;

  // Round-robin pick: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    grant_b = req_b;
    if (req_a && req_b) begin
      grant_b = ~gnt_b_q;
    end
  end

  // Next-state and next-output computation for the change sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rat_d   = rat_q;
    div_d   = div_q;
    en_d    = en_q;
    gnt_b_d = gnt_b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          rat_d   = rat_sel;
          gnt_b_d = grant_b;
          if ((rat_sel == div_q) && (en_q == rat_sel_en)) begin
            // Divider already runs with the requested setting: just acknowledge.
            state_d = ST_ACK;
          end else begin
            en_d    = 1'b0;
            cnt_d   = 8'd0;
            state_d = ST_GATE;
          end
        end
      end

      ST_GATE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == GATE_LAST) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        div_d   = rat_q;
        cnt_d   = 8'd0;
        state_d = ST_ENABLE;
      end

      ST_ENABLE: begin
        // Enable is restored one clock after the ratio load, never together with it.
        en_d = rat_q_en;
        if (cnt_q == enable_last) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ack_a_d = (state_d == ST_ACK) && !gnt_b_d;
    ack_b_d = (state_d == ST_ACK) && gnt_b_d;
    busy_d  = (state_d != ST_IDLE);
  end

  // State, counter, latched ratio and all outputs are registered together.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      rat_q   <= 8'd0;
      div_q   <= RST_RAT;
      en_q    <= RST_EN;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      busy_q  <= 1'b0;
      gnt_b_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rat_q   <= rat_d;
      div_q   <= div_d;
      en_q    <= en_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      busy_q  <= busy_d;
      gnt_b_q <= gnt_b_d;
    end
  end

  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign Div_rat = div_q;
  assign clk_En  = en_q;
  assign busy    = busy_q;
  assign gnt_b   = gnt_b_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// tb_clk_div_cfg_ctrl: directed scenarios followed by randomized requester
// traffic. The reference model works on a per-transaction timeline: at each
// grant it decides fast or full path and computes the clock offsets at which
// clk_En drops, Div_rat loads, clk_En returns and the ack fires.
module tb_clk_div_cfg_ctrl;

  localparam int         G       = 2;
  localparam logic [7:0] RST_RAT = 8'd8;

  logic       ref_clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [7:0] rat_a, rat_b;
  logic       ack_a, ack_b;
  logic [7:0] Div_rat;
  logic       clk_En;
  logic       busy;
  logic       gnt_b;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  logic [7:0] m_div;
  logic       m_en, m_gnt_b, m_busy, m_ack_a, m_ack_b;
  logic       m_active, m_fast;
  logic [7:0] m_R;
  int         m_t, m_k;

  logic       hold_a, hold_b;
  logic [7:0] prev_div;
  logic       prev_en;

  always #5 ref_clk = ~ref_clk;

  clk_div_cfg_ctrl #(
    .GATE_CYC(G),
    .RST_RAT (RST_RAT),
    .RST_EN  (1'b0)
  ) dut (
    .ref_clk(ref_clk),
    .rst    (rst),
    .req_a  (req_a),
    .rat_a  (rat_a),
    .req_b  (req_b),
    .rat_b  (rat_b),
    .ack_a  (ack_a),
    .ack_b  (ack_b),
    .Div_rat(Div_rat),
    .clk_En (clk_En),
    .busy   (busy),
    .gnt_b  (gnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div    = RST_RAT;
    m_en     = 1'b0;
    m_gnt_b  = 1'b1;
    m_busy   = 1'b0;
    m_ack_a  = 1'b0;
    m_ack_b  = 1'b0;
    m_active = 1'b0;
    m_fast   = 1'b0;
    m_R      = 8'd0;
    m_t      = 0;
    m_k      = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic       own_b;
    logic [7:0] r;
    int         s;
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_active) begin
      if (req_a || req_b) begin
        own_b    = (req_a && req_b) ? !m_gnt_b : req_b;
        r        = own_b ? rat_b : rat_a;
        s        = (r >= 8'd2) ? int'(r) : 1;
        m_fast   = (r == m_div) && (m_en == (r >= 8'd2));
        m_k      = m_fast ? 0 : G + s + 1;
        m_active = 1'b1;
        m_t      = 0;
        m_R      = r;
        m_gnt_b  = own_b;
        m_busy   = 1'b1;
        if (!m_fast) m_en = 1'b0;
        m_ack_a  = m_fast && !own_b;
        m_ack_b  = m_fast && own_b;
      end
    end else begin
      m_t++;
      if (m_t == m_k + 1) begin
        m_active = 1'b0;
        m_busy   = 1'b0;
        m_ack_a  = 1'b0;
        m_ack_b  = 1'b0;
      end else begin
        if (!m_fast && m_t == G + 1) m_div = m_R;
        if (!m_fast && m_t == G + 2) m_en = (m_R >= 8'd2);
        m_ack_a = (m_t == m_k) && !m_gnt_b;
        m_ack_b = (m_t == m_k) && m_gnt_b;
      end
    end
  endtask

  task automatic check_all();
    check("div_rat", 32'(Div_rat), 32'(m_div));
    check("clk_en",  32'(clk_En),  32'(m_en));
    check("ack_a",   32'(ack_a),   32'(m_ack_a));
    check("ack_b",   32'(ack_b),   32'(m_ack_b));
    check("busy",    32'(busy),    32'(m_busy));
    check("gnt_b",   32'(gnt_b),   32'(m_gnt_b));
    check("ack_overlap", 32'(ack_a & ack_b), 32'd0);
    // A ratio change must happen with the divider gated on both sides of the edge.
    if (!rst && (Div_rat !== prev_div))
      check("en_low_on_div_change", 32'({prev_en, clk_En}), 32'd0);
    prev_div = Div_rat;
    prev_en  = clk_En;
  endtask

  // Requesters drop their level request once acknowledged unless told to hold it.
  task automatic requester_response();
    if (m_ack_a && !hold_a) req_a = 1'b0;
    if (m_ack_b && !hold_b) req_b = 1'b0;
  endtask

  task automatic step();
    @(posedge ref_clk);
    model_edge();
    #1;
    check_all();
    requester_response();
  endtask

  // Called with the request already set up: the first step is the grant edge.
  // Returns the number of edges after the grant edge until the ack is seen.
  task automatic measure_ack(input logic want_b, output int n);
    n = 0;
    step();
    while (((want_b ? ack_b : ack_a) !== 1'b1) && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((req_a || req_b || m_active) && n < 2000) begin
      step();
      n++;
    end
    check("quiet_timeout", 32'(n >= 2000), 32'd0);
  endtask

  function automatic logic [7:0] pick_rat();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6) return 8'($urandom_range(0, 12));
    else if (sel < 8) return m_div;
    else return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int n;
    int acks;
    rst    = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    rat_a  = 8'd0;
    rat_b  = 8'd0;
    hold_a = 1'b0;
    hold_b = 1'b0;
    prev_div = RST_RAT;
    prev_en  = 1'b0;
    model_reset();

    // reset values
    repeat (2) step();
    rst = 1'b0;
    step();

    // single full-path change to ratio 4
    rat_a = 8'd4;
    req_a = 1'b1;
    measure_ack(1'b0, n);
    check("lat_full_r4", 32'(n), 32'(G + 4 + 1));
    wait_quiet();

    // contention straight out of reset: A first, then B
    rst   = 1'b1;
    rat_a = 8'd6;
    rat_b = 8'd10;
    req_a = 1'b1;
    req_b = 1'b1;
    step();
    rst = 1'b0;
    wait_quiet();
    check("ab_final_div", 32'(Div_rat), 32'd10);
    check("ab_final_gnt", 32'(gnt_b), 32'd1);

    // set 6/enabled, then B asks for the same ratio: ack in the clock after the grant edge
    rat_a = 8'd6;
    req_a = 1'b1;
    wait_quiet();
    rat_b = 8'd6;
    req_b = 1'b1;
    measure_ack(1'b1, n);
    check("lat_fast", 32'(n), 32'd0);
    wait_quiet();

    // bypass ratio 1
    rat_a = 8'd1;
    req_a = 1'b1;
    measure_ack(1'b0, n);
    check("lat_bypass", 32'(n), 32'(G + 2));
    wait_quiet();
    check("bypass_div", 32'(Div_rat), 32'd1);
    check("bypass_en", 32'(clk_En), 32'd0);

    // reset in the middle of ENABLE for ratio 200, request held across it
    rat_a = 8'd200;
    req_a = 1'b1;
    step();
    repeat (G + 1 + 5) step();
    @(negedge ref_clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check("async_rst_div", 32'(Div_rat), 32'(RST_RAT));
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    measure_ack(1'b0, n);
    check("lat_after_reset", 32'(n), 32'(G + 200 + 1));
    wait_quiet();

    // B held high with ratio 255: one long change, then fast acks every 2 clocks
    rat_b  = 8'd255;
    req_b  = 1'b1;
    hold_b = 1'b1;
    measure_ack(1'b1, n);
    check("lat_full_r255", 32'(n), 32'(G + 255 + 1));
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_b === 1'b1) acks++;
    end
    check("fast_repeat_acks", 32'(acks), 32'd10);
    hold_b = 1'b0;
    wait_quiet();

    // randomized traffic from both requesters
    for (int i = 0; i < 8000; i++) begin
      if (!req_a && !m_ack_a && ($urandom_range(0, 5) == 0)) begin
        rat_a  = pick_rat();
        req_a  = 1'b1;
        hold_a = ($urandom_range(0, 3) == 0);
      end
      if (!req_b && !m_ack_b && ($urandom_range(0, 5) == 0)) begin
        rat_b  = pick_rat();
        req_b  = 1'b1;
        hold_b = ($urandom_range(0, 3) == 0);
      end
      // ratio changes after the grant edge must be ignored
      if (m_active && !m_gnt_b && ($urandom_range(0, 3) == 0)) rat_a = 8'($urandom);
      if (m_active && m_gnt_b && ($urandom_range(0, 3) == 0)) rat_b = 8'($urandom);
      step();
      if (m_ack_a && hold_a && ($urandom_range(0, 1) == 0)) hold_a = 1'b0;
      if (m_ack_b && hold_b && ($urandom_range(0, 1) == 0)) hold_b = 1'b0;
    end
    hold_a = 1'b0;
    hold_b = 1'b0;
    wait_quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
